booth_div: RTL and testbench

- Sequential signed integer divider; the inverse companion to the 16x16 -> 32 signed booth multiplier in the same arithmetic datapath.
- Takes a 2*WIDTH-bit signed dividend (e.g. a multiplier product) and a WIDTH-bit signed divisor.
- Returns a WIDTH-bit quotient and remainder after a fixed latency, using a shift-subtract restoring core on magnitudes with sign fix-up.
- Used to check and undo multiplier results on-chip.

---
 rtl/booth_div_if.sv | 25 ++
 rtl/booth_div.sv | 146 ++++++++++++++
 tb/tb_booth_div.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/booth_div_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
// The master drives the request and operands; the slave (divider) returns the results and flags.
interface booth_div_if #(
  parameter int unsigned WIDTH = 16
);
  logic               start;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic               busy;
  logic               done;
  logic               dz;
  logic               ovf;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, dz, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, dz, ovf
  );
endinterface

// File: rtl/booth_div.sv
// Sequential signed divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, restoring core on
// magnitudes with a final sign fix-up and overflow / divide-by-zero detection.
module booth_div #(
  parameter int unsigned WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  booth_div_if.slave  bus
);
  localparam int unsigned DW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(DW);

  typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     dq_q, dq_d;       // dividend magnitude, shifted out as quotient bits shift in
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [WIDTH-1:0]  rmd_q, rmd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;
  logic              ovf_q, ovf_d;

  logic [DW-1:0]     dvd_mag;
  logic [WIDTH-1:0]  dvs_mag;
  logic [WIDTH:0]    rem_shift;
  logic [WIDTH-1:0]  rem_diff;
  logic              rem_ge;
  logic [DW-1:0]     q_limit;
  logic              q_over;

  assign dvd_mag   = bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
  assign dvs_mag   = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
  assign rem_shift = {rem_q, dq_q[DW-1]};
  assign rem_ge    = rem_shift >= {1'b0, dvs_q};
  // When the trial succeeds the true difference is below the divisor, so the low bits are exact.
  assign rem_diff  = rem_shift[WIDTH-1:0] - dvs_q;
  // Negative quotients may reach one step further than positive ones.
  assign q_limit   = (DW'(1) << (WIDTH - 1)) - {{(DW-1){1'b0}}, ~qneg_q};
  assign q_over    = dq_q > q_limit;

  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          dq_d    = dvd_mag;
          dvs_d   = dvs_mag;
          qneg_d  = bus.dividend[DW-1] ^ bus.divisor[WIDTH-1];
          rneg_d  = bus.dividend[DW-1];
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StIter;
        end
      end
      StIter: begin
        rem_d = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
        dq_d  = {dq_q[DW-2:0], rem_ge};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DW - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (dvs_q == '0) begin
          dz_d   = 1'b1;
          ovf_d  = 1'b0;
          quot_d = '0;
          rmd_d  = '0;
        end else if (q_over) begin
          dz_d   = 1'b0;
          ovf_d  = 1'b1;
          quot_d = '0;
          rmd_d  = '0;
        end else begin
          dz_d   = 1'b0;
          ovf_d  = 1'b0;
          quot_d = qneg_q ? -dq_q[WIDTH-1:0] : dq_q[WIDTH-1:0];
          rmd_d  = rneg_q ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      dq_q    <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      rmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.quotient  = quot_q;
  assign bus.remainder = rmd_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dz        = dz_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_booth_div.sv
// Directed and bounded-random checks of the sequential signed divider.
module tb_booth_div;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  booth_div_if #(.WIDTH(16)) bus ();

  booth_div #(.WIDTH(16)) u_dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a rising edge.
  task automatic run_div(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic edz, input logic eovf);
    int n;
    bit seen;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = 16'($urandom);
    check_eq({tag, "_busy"}, 64'(bus.busy), 64'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) seen = 1'b1;
    end
    check_eq({tag, "_lat"}, 64'(n), 64'd33);
    check_eq({tag, "_res"}, {30'd0, bus.dz, bus.ovf, bus.quotient, bus.remainder},
             {30'd0, edz, eovf, eq, er});
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse"}, 64'({bus.done, bus.busy}), 64'd0);
  endtask

  initial begin
    int ndone;
    int dcyc;
    int t[3];
    int nd;
    n_checks = 0;
    n_errors = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset", {30'd0, bus.quotient, bus.remainder, bus.busy, bus.done, bus.dz, bus.ovf},
             64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_div("p100_7", 32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0);

    // Reset in the middle of an operation.
    bus.dividend = 32'd1000;
    bus.divisor  = 16'd3;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("midrst", {30'd0, bus.quotient, bus.remainder, bus.busy, bus.done, bus.dz, bus.ovf},
             64'd0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check_eq("midrst_nodone", 64'(ndone), 64'd0);
    run_div("after_rst", 32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0);

    run_div("mul_inv", 32'd65025, 16'hFF01, 16'hFF01, 16'h0000, 1'b0, 1'b0);
    run_div("p_n", 32'd100, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0);
    run_div("n_p", 32'hFFFF_FF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0);
    run_div("n_n", 32'hFFFF_FF9C, 16'hFFF9, 16'd14, 16'hFFFE, 1'b0, 1'b0);
    run_div("minq", 32'hFFFF_8000, 16'd1, 16'h8000, 16'h0000, 1'b0, 1'b0);
    run_div("posovf", 32'h0000_8000, 16'd1, 16'h0, 16'h0, 1'b0, 1'b1);
    run_div("minneg1", 32'h8000_0000, 16'hFFFF, 16'h0, 16'h0, 1'b0, 1'b1);
    run_div("min8000", 32'h8000_0000, 16'h8000, 16'h0, 16'h0, 1'b0, 1'b1);
    run_div("dz", 32'd1234, 16'd0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Start pulses while busy, and in the done-update cycle, are ignored.
    bus.dividend = 32'd1000;
    bus.divisor  = 16'd10;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    ndone = 0;
    dcyc  = 0;
    for (int i = 1; i <= 80; i++) begin
      if (i == 5 || i == 33) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd77;
        bus.divisor  = 16'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i == 4) check_eq("hold_dz", {47'd0, bus.dz, bus.quotient}, {47'd0, 1'b1, 16'h0});
      if (bus.done) begin
        ndone++;
        dcyc = i;
      end
    end
    bus.start = 1'b0;
    check_eq("ign_count", 64'(ndone), 64'd1);
    check_eq("ign_cycle", 64'(dcyc), 64'd33);
    check_eq("ign_res", {32'd0, bus.quotient, bus.remainder}, {32'd0, 16'd100, 16'd0});
    check_eq("ign_idle", 64'(bus.busy), 64'd0);

    // Start held high: back-to-back divisions.
    bus.dividend = 32'hFFFF_FF9C;
    bus.divisor  = 16'd7;
    bus.start    = 1'b1;
    nd = 0;
    t  = '{0, 0, 0};
    for (int i = 0; i <= 110; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        t[nd] = i;
        nd++;
        if (nd == 3) begin
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    check_eq("b2b_first", 64'(t[0]), 64'd33);
    check_eq("b2b_gap1", 64'(t[1] - t[0]), 64'd34);
    check_eq("b2b_gap2", 64'(t[2] - t[1]), 64'd34);
    check_eq("b2b_res", {32'd0, bus.quotient, bus.remainder}, {32'd0, 16'hFFF2, 16'hFFFE});
    for (int i = 0; i < 40 && bus.busy; i++) begin
      @(posedge clk);
      #1;
    end

    for (int n = 0; n < 200; n++) begin
      logic [31:0] dvd;
      logic [15:0] dvs;
      longint a, b, q64, r64;
      logic [63:0] qv, rv;
      logic [15:0] eq, er;
      logic edz, eovf;
      if (n % 2 == 0) dvd = 32'($signed(16'($urandom)) * $signed(16'($urandom)));
      else            dvd = $urandom;
      if (n % 5 == 4) dvs = 16'($urandom_range(0, 2));
      else            dvs = 16'($urandom);
      a = longint'($signed(dvd));
      b = longint'($signed(dvs));
      edz = 1'b0; eovf = 1'b0; eq = '0; er = '0;
      if (b == 0) begin
        edz = 1'b1;
      end else begin
        q64 = a / b;
        r64 = a % b;
        if (q64 > 32767 || q64 < -32768) begin
          eovf = 1'b1;
        end else begin
          qv = q64;
          rv = r64;
          eq = qv[15:0];
          er = rv[15:0];
        end
      end
      run_div("rand", dvd, dvs, eq, er, edz, eovf);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
